// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parameterised UART transmitter:
// FSM state enum, stop-length encoding, stop timing and parity helpers.
package uart_tx_pkg;

   localparam int unsigned WLEN_W   = 4;
   localparam int unsigned WLEN_MIN = 5;
   localparam int unsigned PAR_MAXW = 9;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } tx_state_e;

   typedef enum logic [1:0] {
      STOP_1   = 2'd0,
      STOP_1P5 = 2'd1,
      STOP_2   = 2'd2
   } stop_len_e;

   // 1.5 stop bits only exist for 5-bit words; otherwise STB selects 2.
   function automatic stop_len_e stop_sel(input logic stb, input logic [WLEN_W-1:0] wlen);
      if (!stb) return STOP_1;
      if (wlen == WLEN_W'(WLEN_MIN)) return STOP_1P5;
      return STOP_2;
   endfunction

   function automatic int unsigned stop_ticks(input stop_len_e sel, input int unsigned ovs);
      case (sel)
         STOP_1P5: return (3 * ovs) / 2;
         STOP_2:   return 2 * ovs;
         default:  return ovs;
      endcase
   endfunction

   // Parity over the first wlen bits only; stick parity overrides the data.
   function automatic logic parity_bit(input logic [PAR_MAXW-1:0] data,
                                       input logic [WLEN_W-1:0]   wlen,
                                       input logic                eps,
                                       input logic                sp);
      logic x;
      x = 1'b0;
      for (int i = 0; i < int'(PAR_MAXW); i++)
         if (WLEN_W'(i) < wlen) x = x ^ data[i];
      if (sp) return !eps;
      return eps ? x : !x;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between a data source and the UART transmitter.
interface uart_tx_if #(parameter int unsigned MAX_WIDTH = 9);
   logic [MAX_WIDTH-1:0] DIN;
   logic                 DVALID;
   logic                 DREADY;

   modport master (output DIN, output DVALID, input DREADY);
   modport slave  (input DIN, input DVALID, output DREADY);
endinterface

// File: rtl/uart_tx_bitcnt.sv
// TXCLK-qualified tick down-counter with terminal count, plus data-bit index.
module uart_tx_bitcnt #(
   parameter int unsigned CW = 5,
   parameter int unsigned BW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_tick,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_bit_clr,
   input  logic          i_bit_inc,
   output logic          o_tc_c,
   output logic [BW-1:0] o_bit_idx
);

   logic [CW-1:0] r_cnt;
   logic [BW-1:0] r_bit;

   // Load holds length-1; the tick seen at zero is the last tick of the period.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                          r_cnt <= '0;
      else if (i_clr)                   r_cnt <= '0;
      else if (i_load)                  r_cnt <= i_load_val;
      else if (i_tick && r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            r_bit <= '0;
      else if (i_bit_clr) r_bit <= '0;
      else if (i_bit_inc) r_bit <= r_bit + BW'(1);
   end

   assign o_tc_c    = i_tick && (r_cnt == '0);
   assign o_bit_idx = r_bit;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: 5..MAX_WIDTH data bits, optional parity,
// 1/1.5/2 stop bits, break control. Define UART_TX_CTS_EN to add CTS_N gating.
module uart_tx_param
   import uart_tx_pkg::*;
#(
   parameter int unsigned MAX_WIDTH = 9,
   parameter int unsigned OVS       = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TXCLK,
   input  logic              CLEAR,
   input  logic [WLEN_W-1:0] WLEN,
   input  logic              STB,
   input  logic              PEN,
   input  logic              EPS,
   input  logic              SP,
   input  logic              BC,
`ifdef UART_TX_CTS_EN
   input  logic              CTS_N,
`endif
   uart_tx_if.slave          dif,
   output logic              SOUT,
   output logic              BUSY,
   output logic              TXFINISHED
);

   localparam int unsigned CW     = $clog2(2 * OVS);
   localparam logic [CW-1:0] LD_BIT = CW'(OVS - 1);

   tx_state_e            r_state, w_state_n;
   logic [MAX_WIDTH-1:0] r_shift;
   logic [WLEN_W-1:0]    r_wlen;
   stop_len_e            r_stop;
   logic                 r_pen, r_par, r_txfinished;

   logic [WLEN_W-1:0]    w_wlen_eff;
   logic [WLEN_W-1:0]    w_bit_idx;
   logic [CW-1:0]        w_cnt_val, w_stop_val;
   logic                 w_tc, w_dready, w_sout;
   logic                 w_capture, w_shift, w_fin;
   logic                 w_cnt_clr, w_cnt_load, w_bit_clr, w_bit_inc;

   uart_tx_bitcnt #(.CW(CW), .BW(WLEN_W)) u_bitcnt (
      .CLK        (CLK),
      .RST        (RST),
      .i_tick     (TXCLK),
      .i_clr      (w_cnt_clr),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_bit_clr  (w_bit_clr),
      .i_bit_inc  (w_bit_inc),
      .o_tc_c     (w_tc),
      .o_bit_idx  (w_bit_idx)
   );

   always_comb begin
      w_wlen_eff = WLEN;
      if (WLEN < WLEN_W'(WLEN_MIN))       w_wlen_eff = WLEN_W'(WLEN_MIN);
      else if (WLEN > WLEN_W'(MAX_WIDTH)) w_wlen_eff = WLEN_W'(MAX_WIDTH);
   end

`ifdef UART_TX_CTS_EN
   assign w_dready = (r_state == IDLE) && !CLEAR && !CTS_N;
`else
   assign w_dready = (r_state == IDLE) && !CLEAR;
`endif

   assign w_stop_val = CW'(stop_ticks(r_stop, OVS) - 1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_n;
   end

   // Next state and counter controls; CLEAR overrides everything, including capture.
   always_comb begin
      w_state_n  = r_state;
      w_capture  = 1'b0;
      w_shift    = 1'b0;
      w_fin      = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_load = 1'b0;
      w_cnt_val  = LD_BIT;
      w_bit_clr  = 1'b0;
      w_bit_inc  = 1'b0;
      if (CLEAR) begin
         w_state_n = IDLE;
         w_cnt_clr = 1'b1;
         w_bit_clr = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: if (dif.DVALID && w_dready) begin
               w_capture  = 1'b1;
               w_cnt_load = 1'b1;
               w_bit_clr  = 1'b1;
               w_state_n  = START;
            end
            START: if (w_tc) begin
               w_cnt_load = 1'b1;
               w_bit_clr  = 1'b1;
               w_state_n  = DATA;
            end
            DATA: if (w_tc) begin
               w_shift    = 1'b1;
               w_cnt_load = 1'b1;
               if (w_bit_idx == r_wlen - WLEN_W'(1)) begin
                  if (r_pen) begin
                     w_state_n = PAR;
                  end else begin
                     w_state_n = STOP;
                     w_cnt_val = w_stop_val;
                  end
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
            PAR: if (w_tc) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = w_stop_val;
               w_state_n  = STOP;
            end
            STOP: if (w_tc) begin
               w_cnt_clr = 1'b1;
               w_bit_clr = 1'b1;
               w_fin     = 1'b1;
               w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   // Frame context is frozen at capture so config changes cannot disturb a frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_shift      <= '0;
         r_wlen       <= WLEN_W'(WLEN_MIN);
         r_stop       <= STOP_1;
         r_pen        <= 1'b0;
         r_par        <= 1'b0;
         r_txfinished <= 1'b0;
      end else begin
         r_txfinished <= w_fin;
         if (w_capture) begin
            r_shift <= dif.DIN;
            r_wlen  <= w_wlen_eff;
            r_stop  <= stop_sel(STB, w_wlen_eff);
            r_pen   <= PEN;
            r_par   <= parity_bit(PAR_MAXW'(dif.DIN), w_wlen_eff, EPS, SP);
         end else if (w_shift) begin
            r_shift <= r_shift >> 1;
         end
      end
   end

   always_comb begin
      w_sout = 1'b1;
      unique case (r_state)
         START:   w_sout = 1'b0;
         DATA:    w_sout = r_shift[0];
         PAR:     w_sout = r_par;
         default: w_sout = 1'b1;
      endcase
   end

   assign dif.DREADY = w_dready;
   assign SOUT       = w_sout & ~BC;
   assign BUSY       = (r_state != IDLE);
   assign TXFINISHED = r_txfinished;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param (OVS=16, MAX_WIDTH=9); TXCLK strobes every 3rd CLK.
module tb_uart_tx_param;

   localparam int unsigned MW  = 9;
   localparam int unsigned OVS = 16;

   logic       CLK, RST, TXCLK, CLEAR, STB, PEN, EPS, SP, BC;
   logic [3:0] WLEN;
`ifdef UART_TX_CTS_EN
   logic       CTS_N;
`endif
   logic       SOUT, BUSY, TXFINISHED;

   uart_tx_if #(.MAX_WIDTH(MW)) dif ();

   uart_tx_param #(.MAX_WIDTH(MW), .OVS(OVS)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .TXCLK      (TXCLK),
      .CLEAR      (CLEAR),
      .WLEN       (WLEN),
      .STB        (STB),
      .PEN        (PEN),
      .EPS        (EPS),
      .SP         (SP),
      .BC         (BC),
`ifdef UART_TX_CTS_EN
      .CTS_N      (CTS_N),
`endif
      .dif        (dif),
      .SOUT       (SOUT),
      .BUSY       (BUSY),
      .TXFINISHED (TXFINISHED)
   );

   typedef struct {
      logic [8:0] din;
      logic [3:0] wlen;
      logic       stb, pen, eps, sp;
      int         exp_bits;
      logic       exp_par;
      int         exp_stop;
      int         exp_total;
   } vec_t;

   vec_t vecs [9];
   logic got [0:2047];
   int   nt, fin_at, p;
   bit   fin_after_tick;
   int   n_total = 0;
   int   n_bad   = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      TXCLK = 1'b0;
      forever begin
         repeat (2) @(negedge CLK);
         TXCLK = 1'b1;
         @(negedge CLK);
         TXCLK = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Samples SOUT once per TXCLK tick until TXFINISHED, stop_ticks, or the cycle budget.
   task automatic watch(input int stop_ticks);
      bit prev_tick;
      prev_tick = 1'b0;
      nt = 0; fin_at = -1; fin_after_tick = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (c > 0) @(negedge CLK);
         #1;
         if (TXFINISHED) begin
            fin_at = nt;
            fin_after_tick = prev_tick;
            return;
         end
         if (nt == stop_ticks) return;
         prev_tick = TXCLK;
         if (TXCLK) begin
            got[nt] = SOUT;
            nt++;
         end
      end
   endtask

   task automatic set_cfg(input int i);
      dif.DIN = vecs[i].din;
      WLEN = vecs[i].wlen;
      STB = vecs[i].stb; PEN = vecs[i].pen; EPS = vecs[i].eps; SP = vecs[i].sp;
   endtask

   // Handshake one word, then scramble the config to show it is not used mid-frame.
   task automatic send(input int i, input bit now);
      if (!now) @(negedge CLK);
      set_cfg(i);
      dif.DVALID = 1'b1;
      #1 chk($sformatf("v%0d.dready_hs", i), dif.DREADY, 1);
      @(posedge CLK);
      @(negedge CLK);
      dif.DVALID = 1'b0;
      WLEN = ~WLEN; STB = ~STB; PEN = ~PEN; EPS = ~EPS; SP = ~SP;
      dif.DIN = ~dif.DIN;
      #1;
      chk($sformatf("v%0d.busy_start", i), BUSY, 1);
      chk($sformatf("v%0d.fin_low_start", i), TXFINISHED, 0);
   endtask

   task automatic seg(input string nm, input logic val, input int len);
      int nbad;
      nbad = 0;
      for (int k = 0; k < len; k++)
         if (p + k >= nt || got[p + k] !== val) nbad++;
      chk({nm, ".wrong_ticks"}, nbad, 0);
      p += len;
   endtask

   task automatic run_vec(input int i, input bit now);
      logic [8:0] d;
      send(i, now);
      watch(100000);
      chk($sformatf("v%0d.busy_fin", i), BUSY, 0);
      chk($sformatf("v%0d.frame_ticks", i), fin_at, vecs[i].exp_total);
      chk($sformatf("v%0d.fin_after_tick", i), fin_after_tick, 1);
      d = vecs[i].din;
      p = 0;
      seg($sformatf("v%0d.start", i), 1'b0, OVS);
      for (int b = 0; b < vecs[i].exp_bits; b++)
         seg($sformatf("v%0d.data%0d", i, b), d[b], OVS);
      if (vecs[i].pen) seg($sformatf("v%0d.par", i), vecs[i].exp_par, OVS);
      seg($sformatf("v%0d.stop", i), 1'b1, vecs[i].exp_stop);
   endtask

   task automatic count_fin(input string nm, input int cycles);
      int n;
      n = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK); #1;
         if (TXFINISHED) n++;
      end
      chk(nm, n, 0);
   endtask

   initial begin
      //         din     wlen   stb   pen   eps   sp   bits par  stop total
      vecs[0] = '{9'h055, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 16, 160};
      vecs[1] = '{9'h1FF, 4'd9,  1'b0, 1'b1, 1'b1, 1'b0, 9, 1'b1, 16, 192};
      vecs[2] = '{9'h015, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 24, 120};
      vecs[3] = '{9'h1EA, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 24, 120};
      vecs[4] = '{9'h003, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 7, 1'b1, 32, 176};
      vecs[5] = '{9'h007, 4'd8,  1'b0, 1'b1, 1'b1, 1'b1, 8, 1'b0, 16, 176};
      vecs[6] = '{9'h100, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 9, 1'b1, 32, 208};
      vecs[7] = '{9'h1C1, 4'd6,  1'b0, 1'b1, 1'b1, 1'b0, 6, 1'b1, 16, 144};
      vecs[8] = '{9'h001, 4'd5,  1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 16, 128};

      RST = 1'b1; CLEAR = 1'b0; BC = 1'b0;
      WLEN = 4'd8; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
      dif.DIN = '0; dif.DVALID = 1'b0;
`ifdef UART_TX_CTS_EN
      CTS_N = 1'b0;
`endif

      // Reset values
      repeat (3) @(negedge CLK);
      #1;
      chk("rst.sout", SOUT, 1);
      chk("rst.busy", BUSY, 0);
      chk("rst.txfinished", TXFINISHED, 0);
      BC = 1'b1;
      #1 chk("rst.bc_sout", SOUT, 0);
      BC = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      #1 chk("rst.dready_after", dif.DREADY, 1);

      for (int i = 0; i < 9; i++) run_vec(i, 1'b0);

      // CLEAR during DATA bit 3 (ticks 65..80), with DVALID raised alongside
      send(0, 1'b0);
      watch(70);
      chk("clr.pre_sout_bit3", SOUT, 0);
      CLEAR = 1'b1;
      dif.DVALID = 1'b1;
      #1 chk("clr.dready_low", dif.DREADY, 0);
      @(negedge CLK); #1;
      chk("clr.sout", SOUT, 1);
      chk("clr.busy", BUSY, 0);
      chk("clr.txfinished", TXFINISHED, 0);
      CLEAR = 1'b0;
      dif.DVALID = 1'b0;
      #1 chk("clr.dready_after", dif.DREADY, 1);
      count_fin("clr.no_fin_pulse", 30);

      // CLEAR beats a simultaneous DVALID in IDLE
      @(negedge CLK);
      CLEAR = 1'b1;
      dif.DVALID = 1'b1;
      @(negedge CLK);
      CLEAR = 1'b0;
      dif.DVALID = 1'b0;
      #1 chk("clr_vs_dvalid.busy", BUSY, 0);
      run_vec(0, 1'b0);

      // Break: line held low, timing and TXFINISHED unchanged
      BC = 1'b1;
      send(0, 1'b0);
      watch(100000);
      begin
         int ones;
         ones = 0;
         for (int k = 0; k < nt; k++) if (got[k] !== 1'b0) ones++;
         chk("bc.nonzero_ticks", ones, 0);
      end
      chk("bc.frame_ticks", fin_at, 160);
      chk("bc.fin_after_tick", fin_after_tick, 1);
      BC = 1'b0;
      #1 chk("bc.sout_released", SOUT, 1);

      // Back-to-back: next word offered in the TXFINISHED cycle
      run_vec(0, 1'b0);
      chk("b2b.dready_idle", dif.DREADY, 1);
      run_vec(2, 1'b1);

      // Reset mid-frame abandons the frame
      send(1, 1'b0);
      watch(40);
      RST = 1'b1;
      #1;
      chk("rstmid.busy", BUSY, 0);
      chk("rstmid.sout", SOUT, 1);
      chk("rstmid.txfinished", TXFINISHED, 0);
      @(negedge CLK);
      RST = 1'b0;
      count_fin("rstmid.no_fin_pulse", 20);
      run_vec(1, 1'b0);

`ifdef UART_TX_CTS_EN
      // Flow control gates only the frame start
      @(negedge CLK);
      CTS_N = 1'b1;
      set_cfg(0);
      dif.DVALID = 1'b1;
      #1 chk("cts.dready_low", dif.DREADY, 0);
      repeat (10) @(negedge CLK);
      #1;
      chk("cts.busy_held", BUSY, 0);
      chk("cts.sout_idle", SOUT, 1);
      @(negedge CLK);
      CTS_N = 1'b0;
      #1 chk("cts.dready_high", dif.DREADY, 1);
      @(posedge CLK);
      @(negedge CLK);
      dif.DVALID = 1'b0;
      CTS_N = 1'b1;
      #1 chk("cts.busy_start", BUSY, 1);
      watch(100000);
      chk("cts.frame_ticks", fin_at, 160);
      CTS_N = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 9: largest data word in bits, legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16: TXCLK ticks per bit period, even, legal range 4..64.
REQ-003 SHALL have port CLK  in  1: system clock.
REQ-004 SHALL have port RST  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port TXCLK  in  1: one-CLK enable strobe at baud*OVS.
REQ-006 SHALL have port CLEAR  in  1: synchronous abort.
REQ-007 SHALL have port WLEN  in  4: data bits per frame.
REQ-008 SHALL have port STB  in  1: stop length; 0 gives 1 bit, 1 gives 1.5 bits if the effective word length is 5, else 2 bits.
REQ-009 SHALL have ports PEN, EPS, SP  in  1 each: parity enable, even select, stick parity.
REQ-010 SHALL have port BC  in  1: break control.
REQ-011 SHALL have port DIN  in  MAX_WIDTH: data word, LSB transmitted first.
REQ-012 SHALL have ports DVALID in 1 and DREADY out 1: word handshake.
REQ-013 SHALL have port SOUT  out  1: serial line, idle high.
REQ-014 SHALL have port BUSY  out  1: frame in progress.
REQ-015 SHALL have port TXFINISHED  out  1: one-CLK pulse at the end of a frame.
REQ-016 SHALL have port CTS_N  in  1: clear-to-send, active-low; present only under UART_TX_CTS_EN.

Function
REQ-017 SHALL implement states IDLE, START, DATA, PAR and STOP.
REQ-018 SHALL assert DREADY = (state==IDLE) && !CLEAR (&& !CTS_N when UART_TX_CTS_EN is defined), combinationally.
REQ-019 SHALL, on DVALID&&DREADY, capture DIN, the effective word length, STB, PEN, EPS and SP, compute parity, and enter START; no config change affects a frame in flight.
REQ-020 SHALL clamp the effective word length to 5 when WLEN<5 and to MAX_WIDTH when WLEN>MAX_WIDTH.
REQ-021 SHALL count TXCLK ticks only; START, each DATA bit and PAR each last exactly OVS ticks.
REQ-022 SHALL make STOP last OVS, 3*OVS/2 or 2*OVS ticks according to the captured STB and word length.
REQ-023 SHALL transition DATA->PAR after the last data bit when PEN=1, else DATA->STOP; PAR->STOP; STOP->IDLE.
REQ-024 SHALL drive the parity bit as follows: SP=1 gives the value !EPS; otherwise EPS=1 gives XOR(data), EPS=0 gives !XOR(data), taken over the captured word length only.
REQ-025 SHALL drive SOUT=1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-026 SHALL force SOUT to 0 while BC=1, leaving FSM and counters unaffected.
REQ-027 SHALL pulse TXFINISHED for one CLK on the CLK edge where STOP->IDLE occurs.
REQ-028 SHALL drive BUSY = (state!=IDLE).
REQ-029 SHALL, on CLEAR=1, enter IDLE on the next CLK and zero the tick and bit counters, with no TXFINISHED pulse.
REQ-030 SHALL give CLEAR priority over a simultaneous DVALID, with no capture.
REQ-031 SHALL, on a back-to-back frame, enter START one CLK after STOP->IDLE at the earliest.
REQ-032 SHALL, when UART_TX_CTS_EN is defined, gate only frame start on CTS_N; deasserting CTS_N mid-frame does not abort.

Reset
REQ-033 SHALL, under RST, give state IDLE, all counters 0, SOUT=1 (BC still forces 0), BUSY=0, TXFINISHED=0, and DREADY=1 after release (CTS permitting).
REQ-034 SHALL, on RST mid-frame, abandon the frame immediately without a TXFINISHED pulse.

Configuration
REQ-035 SHALL, with macro UART_TX_CTS_EN defined, provide port CTS_N and its gating per REQ-018 and REQ-032.
REQ-036 SHALL, without UART_TX_CTS_EN, omit port CTS_N, with DREADY independent of flow control.

Structure
REQ-037 SHALL place the state enum, the stop-length encoding and a parity-function helper in package uart_tx_pkg.
REQ-038 SHALL implement tick/bit timing in sub-module uart_tx_bitcnt: TXCLK-qualified tick counter, terminal-count output, load value from the top level.

Verification (OVS=16, MAX_WIDTH=9)
REQ-039 SHALL cover 8N1 DIN=0x55: SOUT 0,1,0,1,0,1,0,1,0,1, each 16 ticks; TXFINISHED one CLK after tick 160.
REQ-040 SHALL cover WLEN=9, PEN=1, EPS=1, DIN=0x1FF: 9 ones then parity bit 1 then stop; frame 192 ticks.
REQ-041 SHALL cover WLEN=5, STB=1, PEN=0: stop high for 24 ticks; WLEN=3 behaves as 5 bits.
REQ-042 SHALL cover CLEAR during DATA bit 3: SOUT=1 next CLK, BUSY=0, no TXFINISHED, DREADY=1.
REQ-043 SHALL cover BC=1 mid-frame: SOUT=0 throughout; frame timing and TXFINISHED unchanged.
REQ-044 SHALL cover, with UART_TX_CTS_EN, CTS_N=1 with DVALID=1: DREADY=0 and SOUT idle; then CTS_N=0 gives frame start; CTS_N=1 mid-frame leaves the frame completed.
